// File: rtl/fetch_pkg.sv
// Shared constants, the queue entry layout and the epoch width helper for the fetch queue.
package fetch_pkg;

  localparam int FQ_ADDR_W     = 32;
  localparam int FQ_DATA_W     = 32;
  localparam int FQ_INST_BYTES = 4;
  localparam int FQ_OFF_SHIFT  = 2;
  localparam logic [FQ_ADDR_W-1:0] FQ_RESET_PC = 32'h0000_0000;

  // One decoded-stage entry at the default widths: fetch address plus returned word.
  typedef struct packed {
    logic [FQ_ADDR_W-1:0] addr;
    logic [FQ_DATA_W-1:0] data;
  } fetch_entry_t;

  // Enough epoch values that DEPTH back-to-back redirects never alias a live tag.
  function automatic int epoch_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; power-of-two depth.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);

  // Storage array; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush drops everything held.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC, in-order imem requests with DEPTH credits, instruction queue,
// branch/jump redirect with epoch-tagged discard of in-flight responses.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FQ_ADDR_W,
  parameter int                DATA_W     = FQ_DATA_W,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(FQ_RESET_PC),
  parameter int                INST_BYTES = FQ_INST_BYTES,
  parameter int                OFF_SHIFT  = FQ_OFF_SHIFT
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              br_z,
  input  logic              br_b,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc
);

  localparam int EPOCH_W = epoch_w(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int STALE_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [EPOCH_W-1:0] epoch;
  } tag_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0]  pc_q;
  logic [EPOCH_W-1:0] epoch_q;
  // Responses still owed by memory for requests accepted before the last reset.
  logic [STALE_W-1:0] stale_q;
  logic [STALE_W-1:0] stale_pend;

  logic               br_taken, redirect;
  logic [ADDR_W-1:0]  br_target, target;
  logic               credit_ok, accept;
  logic               rsp_stale, rsp_pop, rsp_keep, inst_pop;

  tag_t               tag_push, tag_head;
  logic               tag_full, tag_empty;
  logic [CNT_W-1:0]   tag_count;
  entry_t             q_push, q_head;
  logic               q_full, q_empty;
  logic [CNT_W-1:0]   q_count;

  assign br_taken  = br_z & br_b;
  assign redirect  = jmp_valid | br_taken;
  assign br_target = br_pc + ADDR_W'(INST_BYTES) + (br_offset << OFF_SHIFT);
  assign target    = jmp_valid ? jmp_addr : br_target;

  // Queued words plus words still owed must fit in the queue, so a push never overflows.
  assign credit_ok = ~q_full & ~tag_full &
                     (({1'b0, q_count} + {1'b0, tag_count}) < (CNT_W + 1)'(DEPTH));

  assign imem_req_valid = ~reset & ~redirect & credit_ok;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;
  assign pc             = pc_q;

  // Pre-reset responses come back first because memory answers in order.
  assign rsp_stale = imem_rsp_valid & (stale_q != '0);
  assign rsp_pop   = imem_rsp_valid & ~rsp_stale & ~tag_empty;
  assign rsp_keep  = rsp_pop & (tag_head.epoch == epoch_q) & ~redirect & ~reset;

  assign tag_push = '{addr: pc_q, epoch: epoch_q};
  assign q_push   = '{addr: tag_head.addr, data: imem_rsp_data};

  assign inst_valid = ~reset & ~q_empty;
  assign inst_data  = inst_valid ? q_head.data : '0;
  assign inst_pc    = inst_valid ? q_head.addr : '0;
  assign inst_pop   = inst_valid & inst_ready;

  // Count of owed-but-orphaned responses as it stands after this cycle's response.
  always_comb begin
    stale_pend = stale_q + STALE_W'(tag_count);
    if (imem_rsp_valid && (stale_pend != '0)) stale_pend = stale_pend - STALE_W'(1);
  end

  // PC, epoch and orphan counter; the counter survives reset since memory keeps answering.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      epoch_q <= '0;
      stale_q <= stale_pend;
    end else begin
      if (redirect) begin
        pc_q    <= target;
        epoch_q <= epoch_q + EPOCH_W'(1);
      end else if (accept) begin
        pc_q <= pc_q + ADDR_W'(INST_BYTES);
      end
      if (rsp_stale) stale_q <= stale_q - STALE_W'(1);
    end
  end

  sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(DEPTH)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (accept),
    .push_data (tag_push),
    .pop       (rsp_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_inst_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data (q_push),
    .pop       (inst_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table, corner sequences, random traffic vs. a queue model.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        br_z, br_b;
  logic [31:0] br_pc, br_offset;
  logic        jmp_valid;
  logic [31:0] jmp_addr;
  logic        inst_valid;
  logic [31:0] inst_data, inst_pc;
  logic        inst_ready;
  logic [31:0] pc;

  always #5 clock = ~clock;

  fetch_queue_unit #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .br_z(br_z), .br_b(br_b), .br_pc(br_pc), .br_offset(br_offset),
    .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .pc(pc)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [31:0] due; } mem_t;
  typedef struct packed { logic [31:0] addr; logic live; logic counted; } out_t;
  typedef struct {
    logic rst; logic jv; logic [31:0] ja; logic bz; logic bb; logic [31:0] bpc; logic [31:0] boff;
    logic e_rv; logic [31:0] e_ra; logic e_iv; logic [31:0] e_ipc;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int gen = 0;
  bit known = 0;
  int lat_min = 1, lat_max = 1, rsp_pct = 100;

  mem_t         mem_q[$];
  out_t         outs[$];
  fetch_entry_t iq[$];
  logic [31:0]  m_pc;

  logic        s_req_valid, s_inst_valid;
  logic [31:0] s_req_addr, s_inst_pc, s_inst_data, s_pc;

  function automatic logic [31:0] mdata(input logic [31:0] addr, input int g);
    return (addr * 32'h9E37_79B1) ^ {g[7:0], 24'h0} ^ 32'h1357_9BDF;
  endfunction

  function automatic int counted_outs();
    int n = 0;
    foreach (outs[i]) if (outs[i].counted) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model, wait next negedge.
  task automatic cycle(input logic rst, input logic rdy, input logic irdy,
                       input logic bz, input logic bb, input logic [31:0] bpc, input logic [31:0] boff,
                       input logic jv, input logic [31:0] ja);
    logic redir, exp_rv, exp_iv, do_pop;
    out_t o;
    reset = rst; imem_req_ready = rdy; inst_ready = irdy;
    br_z = bz; br_b = bb; br_pc = bpc; br_offset = boff; jmp_valid = jv; jmp_addr = ja;
    if (mem_q.size() > 0 && mem_q[0].due <= 32'(cyc) && $urandom_range(0, 99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr; s_pc = pc;
    s_inst_valid = inst_valid; s_inst_pc = inst_pc; s_inst_data = inst_data;

    redir  = !rst && (jv || (bz && bb));
    exp_rv = !rst && !redir && (iq.size() + counted_outs() < DEPTH);
    exp_iv = !rst && (iq.size() > 0);
    if (known) begin
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      check("pc", pc, m_pc);
      if (exp_rv) check("req_addr", imem_req_addr, m_pc);
      check("inst_valid", 32'(inst_valid), 32'(exp_iv));
      if (exp_iv && inst_valid) begin
        check("inst_pc", inst_pc, iq[0].addr);
        check("inst_data", inst_data, iq[0].data);
      end
    end
    if (imem_req_valid && imem_req_ready)
      mem_q.push_back('{addr: imem_req_addr, data: mdata(imem_req_addr, gen),
                        due: 32'(cyc) + 32'($urandom_range(lat_min, lat_max))});

    do_pop = exp_iv && irdy && !redir;
    if (do_pop) void'(iq.pop_front());
    if (imem_rsp_valid && outs.size() > 0) begin
      o = outs.pop_front();
      if (o.live && !rst && !redir) iq.push_back('{addr: o.addr, data: imem_rsp_data});
    end
    if (rst) begin
      iq.delete();
      foreach (outs[i]) begin outs[i].live = 1'b0; outs[i].counted = 1'b0; end
      m_pc = 32'h0;
      gen++;
      known = 1;
    end else if (redir) begin
      iq.delete();
      foreach (outs[i]) outs[i].live = 1'b0;
      m_pc = jv ? ja : (bpc + 32'd4 + boff * 32'd4);
    end else if (exp_rv && rdy) begin
      outs.push_back('{addr: m_pc, live: 1'b1, counted: 1'b1});
      m_pc = m_pc + 32'd4;
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input logic irdy);
    cycle(1'b0, 1'b1, irdy, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rst_cycle();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && mem_q.size() > 0; i++) idle(1'b1);
  endtask

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    bit found;

    //           rst  jv  ja          bz  bb  bpc     boff   e_rv e_ra       e_iv e_ipc
    tbl[0]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b0,32'h0,     1'b0,32'h0};
    tbl[1]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h0,     1'b0,32'h0};
    tbl[2]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h4,     1'b0,32'h0};
    tbl[3]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h8,     1'b1,32'h0};
    tbl[4]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'hC,     1'b1,32'h4};
    tbl[5]  = '{1'b0,1'b0,32'h0,      1'b1,1'b1,32'h8, 32'h3, 1'b0,32'h0,     1'b1,32'h8};
    tbl[6]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h18,    1'b0,32'h0};
    tbl[7]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h1C,    1'b0,32'h0};
    tbl[8]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h20,    1'b1,32'h18};
    tbl[9]  = '{1'b0,1'b1,32'h100,    1'b1,1'b1,32'h40,32'h1, 1'b0,32'h0,     1'b1,32'h1C};
    tbl[10] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h100,   1'b0,32'h0};
    tbl[11] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h104,   1'b0,32'h0};
    tbl[12] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h108,   1'b1,32'h100};
    tbl[13] = '{1'b0,1'b0,32'h0,      1'b0,1'b1,32'h0, 32'h5, 1'b1,32'h10C,   1'b1,32'h104};
    tbl[14] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,32'h0, 32'h0, 1'b1,32'h110,   1'b1,32'h108};

    reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    br_z = 1'b0; br_b = 1'b0; br_pc = '0; br_offset = '0; jmp_valid = 1'b0; jmp_addr = '0;
    inst_ready = 1'b1; m_pc = '0;
    @(negedge clock);

    // Directed table: memory always ready, 1-cycle latency, decode always ready.
    lat_min = 1; lat_max = 1; rsp_pct = 100;
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].rst, 1'b1, 1'b1, tbl[i].bz, tbl[i].bb, tbl[i].bpc, tbl[i].boff, tbl[i].jv, tbl[i].ja);
      check($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) check($sformatf("tbl%0d_req_addr", i), s_req_addr, tbl[i].e_ra);
      check($sformatf("tbl%0d_inst_valid", i), 32'(s_inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        check($sformatf("tbl%0d_inst_pc", i), s_inst_pc, tbl[i].e_ipc);
        check($sformatf("tbl%0d_inst_data", i), s_inst_data, mdata(tbl[i].e_ipc, gen));
      end
    end

    // Decode stalled: exactly DEPTH requests, then drain in order and resume at 0x10.
    drain(); rst_cycle();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      if (s_req_valid) acc++;
    end
    check("stall_req_count", 32'(acc), 32'(DEPTH));
    check("stall_req_valid_low", 32'(s_req_valid), 32'h0);
    found = 0; n = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1'b1);
      if (s_inst_valid && n < 4) begin
        check("stall_drain_pc", s_inst_pc, 32'(n * 4));
        n++;
      end
      if (!found && s_req_valid) begin
        found = 1;
        check("stall_resume_addr", s_req_addr, 32'h10);
      end
    end
    check("stall_resume_seen", 32'(found), 32'h1);
    check("stall_drain_count", 32'(n), 32'h4);

    // Taken branch with two requests in flight.
    drain(); rst_cycle();
    lat_min = 3; lat_max = 3;
    idle(1'b1); idle(1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h3, 1'b0, 32'h0);
    check("br_no_req_on_redirect", 32'(s_req_valid), 32'h0);
    idle(1'b1);
    check("br_target_req_valid", 32'(s_req_valid), 32'h1);
    check("br_target_req_addr", s_req_addr, 32'h18);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle(1'b1);
      if (s_inst_valid) begin
        found = 1;
        check("br_first_inst_pc", s_inst_pc, 32'h18);
      end
    end
    check("br_first_inst_seen", 32'(found), 32'h1);

    // PC wrap at the top of the address space.
    drain(); rst_cycle();
    lat_min = 1; lat_max = 1;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    idle(1'b1);
    check("wrap_req_addr", s_req_addr, 32'hFFFF_FFFC);
    check("wrap_req_valid", 32'(s_req_valid), 32'h1);
    idle(1'b1);
    check("wrap_pc", s_pc, 32'h0);

    // Reset with three requests outstanding: their late responses must never surface.
    drain(); rst_cycle();
    lat_min = 6; lat_max = 6;
    idle(1'b1); idle(1'b1); idle(1'b1);
    check("rst_three_outstanding", 32'(mem_q.size()), 32'h3);
    rst_cycle();
    idle(1'b1);
    check("rst_next_req_addr", s_req_addr, 32'h0);
    check("rst_next_req_valid", 32'(s_req_valid), 32'h1);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      idle(1'b1);
      if (s_inst_valid) begin
        found = 1;
        check("rst_first_inst_pc", s_inst_pc, 32'h0);
        check("rst_first_inst_data", s_inst_data, mdata(32'h0, gen));
      end
    end
    check("rst_first_inst_seen", 32'(found), 32'h1);

    // Random traffic against the model.
    lat_min = 1; lat_max = 4; rsp_pct = 75;
    for (int i = 0; i < 1500; i++) begin
      int o;
      o = $urandom_range(0, 15) - 8;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom & 32'h0000_FFFC, 32'(o),
            ($urandom_range(0, 39) == 0), $urandom & 32'hFFFF_FFFC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-register fetch stage.
- Holds the PC and issues in-order requests to instruction memory, with up to DEPTH requests outstanding.
- Buffers returned words in a DEPTH-entry queue and hands them to decode over a valid/ready handshake.
- Resolves taken branches (Z & B) and absolute jumps with a queue flush; stale in-flight responses are dropped by epoch tagging.

Parameters:
- ADDR_W, 32, width of PC, addresses and branch offset.
- DATA_W, 32, instruction word width.
- DEPTH, 4, instruction queue entries and maximum outstanding requests. Power of two, at least 2.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- INST_BYTES, 4, sequential PC increment.
- OFF_SHIFT, 2, left shift applied to the branch offset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_W  fetch address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response word valid. Responses return in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  DATA_W  response word.
- br_z  in  1  ALU zero flag.
- br_b  in  1  branch instruction flag.
- br_pc  in  ADDR_W  PC of the resolving branch.
- br_offset  in  ADDR_W  sign-extended branch offset, in words.
- jmp_valid  in  1  absolute redirect.
- jmp_addr  in  ADDR_W  jump target.
- inst_valid  out  1  queue head valid.
- inst_data  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  head instruction address.
- inst_ready  in  1  decode consumes head.
- pc  out  ADDR_W  next address to be requested.

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, queue empty, outstanding=0, epoch=0. All outputs low except pc. Reset overrides every other input, including mid-request; responses arriving after reset are treated as stale.
- Request rule: imem_req_valid=1 iff not reset, no redirect this cycle, and occupancy+outstanding < DEPTH. imem_req_addr=pc.
- On accept (valid & ready): pc <= pc + INST_BYTES (mod 2^ADDR_W wrap), outstanding++. A side FIFO of depth DEPTH records {addr, epoch} per request.
- On imem_rsp_valid: pop the side FIFO. If the tag epoch equals the current epoch, push {data, addr} into the queue; otherwise discard. Either way, outstanding--.
- Accept and response in the same cycle: outstanding unchanged.
- Handshake: head is popped on inst_valid & inst_ready. A push and a pop in the same cycle keep occupancy unchanged; the credit rule guarantees a push never finds the queue full.
- Redirect: br_taken = br_z & br_b; target = br_pc + INST_BYTES + (br_offset << OFF_SHIFT), truncated to ADDR_W. jmp_valid has priority over br_taken.
- On redirect: pc <= target; queue flushed; epoch toggles; no request is issued that cycle. inst_valid is 0 the following cycle.
- Outstanding requests are not cancelled. Their responses are dropped by epoch mismatch.
- Latency: a redirect at cycle t gives a request for the target at t+1. The first target instruction appears at the earliest 2 cycles after memory acceptance of that request (1-cycle memory plus queue register).
- Epoch is 1 bit. This is safe because a second redirect can only arrive after stale responses are drained, or the drain is bounded by DEPTH. Epoch must widen to clog2(DEPTH)+1 if back-to-back redirects with outstanding requests are permitted. Decision: use clog2(DEPTH)+1 bits.
- Simultaneous redirect and inst_ready: the flush wins and the head is discarded.
- Simultaneous redirect and response: the response is checked against the old epoch, then dropped.

Decomposition:
- Shared package fetch_pkg: INST_BYTES, OFF_SHIFT, RESET_PC default, queue entry struct {addr, data}, epoch width function.
- Sub-module sync_fifo (parametrised width/depth, push/pop/flush, full/empty/count), instantiated twice: instruction queue and request-tag FIFO.
- Redirect and adder logic stays in the top module.

Test Plan:
- Reset, memory always ready, 1-cycle latency, inst_ready=1 -> requests at 0x0,0x4,0x8,... on consecutive cycles. inst_pc follows the same sequence; inst_data matches memory.
- inst_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, then imem_req_valid=0. After release, the 4 entries drain in order and requests resume at 0x10.
- Branch with br_z=1, br_b=1, br_pc=0x8, br_offset=3, with 2 requests in flight -> next request at 0x18. The two stale responses are discarded; the first inst_pc out is 0x18.
- br_b=1, br_z=0 -> no redirect, sequential flow is unaffected. jmp_valid and a taken branch in the same cycle -> jmp_addr is used.
- pc=0xFFFFFFFC, request accepted -> pc wraps to 0x00000000.
- reset asserted with 3 requests outstanding -> the next request is at RESET_PC, and none of the 3 late responses reach inst_valid.
